load_control_sequencer: RTL and testbench

LOAD_CONTROL_SEQUENCER -- requirements
Module: load_control_sequencer

---
 rtl/loadSeqPkg.sv | 66 ++++++
 rtl/load_seq_queue.sv | 49 ++++
 rtl/load_control_sequencer.sv | 128 ++++++++++++
 tb/tb_load_control_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loadSeqPkg.sv
// Load sequencer package: request classes, control words and per-class step tables.
package loadSeqPkg;

  localparam int unsigned CW          = 5;
  localparam int unsigned NUM_CLASSES = 16;
  localparam int unsigned TBL_STEPS   = 4;
  localparam int unsigned LEN_W       = 3;

  typedef logic [CW-1:0] ctrl_t;

  localparam ctrl_t NO_OP         = 5'd0;
  localparam ctrl_t NEXTPC_IMM21B = 5'd1;
  localparam ctrl_t NEXTPC_IMM24  = 5'd2;
  localparam ctrl_t ADDR_GEN      = 5'd3;
  localparam ctrl_t MEM_READ      = 5'd4;
  localparam ctrl_t WB_LOAD       = 5'd5;
  localparam ctrl_t ADDR_INC      = 5'd6;
  localparam ctrl_t WB_ALU        = 5'd7;
  localparam ctrl_t NEXTPC_REG    = 5'd8;

  typedef enum logic [3:0] {
    CLS_NOP     = 4'd0,
    CLS_JAL     = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_BRANCH  = 4'd3,
    CLS_LOADINC = 4'd4,
    CLS_ALU     = 4'd5,
    CLS_BRREG   = 4'd6
  } ld_class_e;

  // Queue entry: class plus the condition captured at accept time.
  typedef struct packed {
    logic [3:0] cls;
    logic       cond;
  } req_t;

  localparam logic [LEN_W-1:0] SEQ_LEN [NUM_CLASSES] = '{
    3'd0, 3'd1, 3'd3, 3'd1, 3'd2, 3'd1, 3'd1, 3'd0,
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0
  };

  localparam logic SEQ_COND [NUM_CLASSES] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0
  };

  localparam ctrl_t SEQ_TABLE [NUM_CLASSES][TBL_STEPS] = '{
    '{NO_OP,         NO_OP,    NO_OP,   NO_OP},
    '{NEXTPC_IMM21B, NO_OP,    NO_OP,   NO_OP},
    '{ADDR_GEN,      MEM_READ, WB_LOAD, NO_OP},
    '{NEXTPC_IMM24,  NO_OP,    NO_OP,   NO_OP},
    '{ADDR_INC,      MEM_READ, NO_OP,   NO_OP},
    '{WB_ALU,        NO_OP,    NO_OP,   NO_OP},
    '{NEXTPC_REG,    NO_OP,    NO_OP,   NO_OP},
    '{default: NO_OP},
    '{default: NO_OP},
    '{default: NO_OP},
    '{default: NO_OP},
    '{default: NO_OP},
    '{default: NO_OP},
    '{default: NO_OP},
    '{default: NO_OP},
    '{default: NO_OP}
  };

endpackage

// File: rtl/load_seq_queue.sv
// Request FIFO for the load sequencer; extra pointer bit separates full from empty.
module load_seq_queue #(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned W      = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(QDEPTH):0]      count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [QDEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;

  // Pointer update; clear wins over push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
    end
  end

  // Entry storage; data needs no reset since pointers qualify it.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_q[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_q[AW-1:0]];
  assign count = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/load_control_sequencer.sv
// Load control sequencer: expands queued load requests into per-cycle control words.
// Optional LOAD_SEQ_PERF_EN adds a 32-bit perf_steps counter of emitted valid steps.
module load_control_sequencer
  import loadSeqPkg::*;
#(
  parameter int unsigned CTRL_W   = 5,
  parameter int unsigned STEP_MAX = 3,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_class,
  input  logic              req_cond,
  output logic [CTRL_W-1:0] load_control,
  output logic              load_valid,
`ifdef LOAD_SEQ_PERF_EN
  output logic [31:0]       perf_steps,
`endif
  output logic              busy
);

  localparam int unsigned QW     = $bits(req_t);
  localparam int unsigned PTR_W  = $clog2(QDEPTH) + 1;
  localparam int unsigned STEP_W = 2;

  typedef enum logic {IDLE, STEP} state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  ctrl_t               ctrl_d;
  logic                valid_d;
  logic                push, pop, avail, last, collapse, cur_real;
  logic [LEN_W-1:0]    raw_len, cur_len;
  logic [PTR_W-1:0]    q_count, remain;
  logic [QW-1:0]       q_dout;
  logic                q_empty, q_full;
  req_t                head;

  load_seq_queue #(.QDEPTH(QDEPTH), .W(QW)) u_queue (
    .clk   (clk),
    .reset (reset),
    .clear (flush && enable),
    .push  (push),
    .pop   (pop),
    .din   ({req_class, req_cond}),
    .dout  (q_dout),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // Next-state and next-output logic; an empty queue bypasses the incoming request.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    ctrl_d   = NO_OP;
    valid_d  = 1'b0;
    pop      = 1'b0;
    push     = req_valid && !q_full && enable && !flush;
    avail    = !q_empty || push;
    head     = q_empty ? req_t'({req_class, req_cond}) : req_t'(q_dout);
    collapse = SEQ_COND[head.cls] && !head.cond;
    raw_len  = SEQ_LEN[head.cls];
    cur_real = 1'b1;
    cur_len  = raw_len;
    if (collapse || raw_len == '0) begin
      cur_len  = LEN_W'(1);
      cur_real = 1'b0;
    end else if (raw_len > LEN_W'(STEP_MAX)) begin
      cur_len  = LEN_W'(STEP_MAX);
    end
    last   = (LEN_W'(step_q) == cur_len - LEN_W'(1));
    remain = q_count + PTR_W'(push) - PTR_W'(1);

    if (flush) begin
      state_d = IDLE;
      step_d  = '0;
    end else if (avail) begin
      ctrl_d  = cur_real ? SEQ_TABLE[head.cls][step_q] : NO_OP;
      valid_d = cur_real;
      if (last) begin
        pop     = enable;
        step_d  = '0;
        state_d = (remain != '0) ? STEP : IDLE;
      end else begin
        step_d  = step_q + STEP_W'(1);
        state_d = STEP;
      end
    end else begin
      state_d = IDLE;
      step_d  = '0;
    end
  end

  // State and output registers; enable low freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      load_control <= CTRL_W'(NO_OP);
      load_valid   <= 1'b0;
    end else if (enable) begin
      state_q      <= state_d;
      step_q       <= step_d;
      load_control <= CTRL_W'(ctrl_d);
      load_valid   <= valid_d;
    end
  end

  assign req_ready = !q_full;
  assign busy      = !q_empty || (state_q == STEP);

`ifdef LOAD_SEQ_PERF_EN
  // Count cycles presenting a real step while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_steps <= '0;
    end else if (enable && load_valid) begin
      perf_steps <= perf_steps + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_control_sequencer.sv
// Self-checking bench for load_control_sequencer with a word-stream scoreboard.
module tb_load_control_sequencer;
  import loadSeqPkg::*;

  localparam int QD = 2;

  logic       clk, reset, enable, flush, req_valid, req_cond;
  logic [3:0] req_class;
  logic       req_ready, load_valid, busy;
  logic [4:0] load_control;
`ifdef LOAD_SEQ_PERF_EN
  logic [31:0] perf_steps;
`endif

  typedef struct {
    logic [4:0] ctrl;
    bit         valid;
    bit         last;
  } exp_t;

  exp_t       exp_q[$];
  int         pend;
  logic [4:0] exp_ctrl;
  bit         exp_valid;
  int         errors, checks;

  load_control_sequencer #(.CTRL_W(5), .STEP_MAX(3), .QDEPTH(QD)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_class    (req_class),
    .req_cond     (req_cond),
    .load_control (load_control),
    .load_valid   (load_valid),
`ifdef LOAD_SEQ_PERF_EN
    .perf_steps   (perf_steps),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word sequence for one accepted request.
  task automatic push_words(input logic [3:0] cls, input logic cond);
    logic [4:0] w[4];
    int n;
    bit v;
    n = 1; v = 1'b1;
    for (int i = 0; i < 4; i++) w[i] = NO_OP;
    case (cls)
      CLS_JAL:     w[0] = NEXTPC_IMM21B;
      CLS_LOAD:    begin n = 3; w[0] = ADDR_GEN; w[1] = MEM_READ; w[2] = WB_LOAD; end
      CLS_BRANCH:  if (cond) w[0] = NEXTPC_IMM24; else v = 1'b0;
      CLS_LOADINC: begin n = 2; w[0] = ADDR_INC; w[1] = MEM_READ; end
      CLS_ALU:     w[0] = WB_ALU;
      CLS_BRREG:   if (cond) w[0] = NEXTPC_REG; else v = 1'b0;
      default:     v = 1'b0;
    endcase
    for (int i = 0; i < n; i++) exp_q.push_back('{ctrl: w[i], valid: v, last: (i == n - 1)});
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend = 0;
    exp_ctrl = NO_OP;
    exp_valid = 1'b0;
  endtask

  // Advance one clock, updating the model at the edge; returns at the next falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (reset) model_clear();
    else if (enable) begin
      if (flush) model_clear();
      else begin
        if (req_valid && pend < QD) begin
          push_words(req_class, req_cond);
          pend++;
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          exp_ctrl = e.ctrl;
          exp_valid = e.valid;
          if (e.last) pend--;
        end else begin
          exp_ctrl = NO_OP;
          exp_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    enable = 1'b1; flush = 1'b0; req_valid = 1'b0; req_class = 4'd0; req_cond = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    if (load_control !== NO_OP || load_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out: got %0d/%0b want 0/0", load_control, load_valid);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_status: busy %0b ready %0b want 0 1", busy, req_ready);
    end
    checks++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_valid = 1'b1; req_class = CLS_JAL;
    tick();
    req_valid = 1'b0;
    if (load_control !== NEXTPC_IMM21B || load_valid !== 1'b1) begin
      errors++; $display("FAIL single_c1: got %0d/%0b want %0d/1", load_control, load_valid, NEXTPC_IMM21B);
    end
    checks++;
    tick();
    if (load_control !== NO_OP || load_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_c2: got %0d/%0b busy %0b want 0/0 0", load_control, load_valid, busy);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] cls [6] = '{CLS_LOAD, CLS_ALU, 4'd0, 4'd0, 4'd0, 4'd0};
    bit         vld [6] = '{1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      req_valid = vld[i]; req_class = cls[i];
      tick();
      if (load_control !== exp_ctrl || load_valid !== exp_valid) begin
        errors++; $display("FAIL b2b_out[%0d]: got %0d/%0b want %0d/%0b", i, load_control, load_valid, exp_ctrl, exp_valid);
      end
      checks++;
      if (busy !== (pend != 0) || req_ready !== (pend < QD)) begin
        errors++; $display("FAIL b2b_status[%0d]: busy %0b ready %0b want %0b %0b", i, busy, req_ready, pend != 0, pend < QD);
      end
      checks++;
    end
  endtask

  task automatic test_cond();
    logic [3:0] cls [9] = '{CLS_BRANCH, CLS_BRANCH, CLS_BRREG, CLS_BRREG, 4'd9, CLS_LOADINC, 4'd0, 4'd0, 4'd0};
    bit         cnd [9] = '{0, 1, 0, 1, 1, 1, 0, 0, 0};
    bit         vld [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      req_valid = vld[i]; req_class = cls[i]; req_cond = cnd[i];
      tick();
      if (load_control !== exp_ctrl || load_valid !== exp_valid) begin
        errors++; $display("FAIL cond_out[%0d]: got %0d/%0b want %0d/%0b", i, load_control, load_valid, exp_ctrl, exp_valid);
      end
      checks++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_full();
    logic [3:0] cls [3] = '{CLS_LOAD, CLS_JAL, CLS_ALU};
    int idx, vcount;
    bit acc, saw_block;
    idx = 0; vcount = 0; saw_block = 1'b0;
    for (int c = 0; c < 12; c++) begin
      req_valid = (idx < 3);
      req_class = (idx < 3) ? cls[idx] : 4'd0;
      acc = req_valid && (pend < QD);
      if (req_valid && pend >= QD) saw_block = 1'b1;
      if (req_ready !== (pend < QD)) begin
        errors++; $display("FAIL full_ready[%0d]: got %0b want %0b", c, req_ready, pend < QD);
      end
      checks++;
      tick();
      if (acc) idx++;
      if (load_valid === 1'b1) vcount++;
      if (load_control !== exp_ctrl || load_valid !== exp_valid) begin
        errors++; $display("FAIL full_out[%0d]: got %0d/%0b want %0d/%0b", c, load_control, load_valid, exp_ctrl, exp_valid);
      end
      checks++;
    end
    req_valid = 1'b0;
    if (vcount != 5 || !saw_block) begin
      errors++; $display("FAIL full_count: valid words %0d blocked %0b want 5 1", vcount, saw_block);
    end
    checks++;
  endtask

  task automatic test_stall();
    req_valid = 1'b1; req_class = CLS_LOAD;
    tick();
    req_valid = 1'b0;
    tick();
    enable = 1'b0; flush = 1'b1; req_valid = 1'b1; req_class = CLS_JAL;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (load_control !== MEM_READ || load_valid !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: got %0d/%0b busy %0b want %0d/1 1", i, load_control, load_valid, busy, MEM_READ);
      end
      checks++;
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (load_control !== exp_ctrl || load_valid !== exp_valid || busy !== (pend != 0)) begin
        errors++; $display("FAIL stall_resume[%0d]: got %0d/%0b busy %0b want %0d/%0b", i, load_control, load_valid, busy, exp_ctrl, exp_valid);
      end
      checks++;
    end
  endtask

  task automatic test_flush();
    logic [3:0] cls [6] = '{CLS_LOAD, CLS_JAL, CLS_ALU, 4'd0, 4'd0, 4'd0};
    bit         vld [6] = '{1, 1, 1, 0, 0, 0};
    bit         fl  [6] = '{0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      req_valid = vld[i]; req_class = cls[i]; flush = fl[i];
      tick();
      if (load_control !== exp_ctrl || load_valid !== exp_valid || busy !== (pend != 0)) begin
        errors++; $display("FAIL flush_out[%0d]: got %0d/%0b busy %0b want %0d/%0b %0b", i, load_control, load_valid, busy, exp_ctrl, exp_valid, pend != 0);
      end
      checks++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_class = CLS_LOAD;
    tick();
    req_class = CLS_JAL;
    tick();
    req_valid = 1'b0;
    #2 reset = 1'b1;
    model_clear();
    #1;
    if (load_control !== NO_OP || load_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_async: got %0d/%0b busy %0b ready %0b want 0/0 0 1", load_control, load_valid, busy, req_ready);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (load_control !== NO_OP || load_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rstmid_after[%0d]: got %0d/%0b busy %0b want 0/0 0", i, load_control, load_valid, busy);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      enable    = ($urandom_range(9) != 0);
      flush     = ($urandom_range(24) == 0);
      req_valid = $urandom_range(1);
      req_class = 4'($urandom_range(15));
      req_cond  = $urandom_range(1);
      tick();
      if (load_control !== exp_ctrl || load_valid !== exp_valid) begin
        errors++; $display("FAIL rand_out[%0d]: got %0d/%0b want %0d/%0b", i, load_control, load_valid, exp_ctrl, exp_valid);
      end
      checks++;
      if (busy !== (pend != 0) || req_ready !== (pend < QD)) begin
        errors++; $display("FAIL rand_status[%0d]: busy %0b ready %0b want %0b %0b", i, busy, req_ready, pend != 0, pend < QD);
      end
      checks++;
    end
    idle_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_cond();
    test_full();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
